// File: rtl/counter_cmd_gen.sv
// rtl/counter_cmd_gen.sv - button synchronizer, debouncer and auto-repeat step/load strobe generator
// Produces single-cycle enable/dec/load strobes and a held load_value for an up/down counter.
module counter_cmd_gen #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_load,
  input  logic [N-1:0] load_sw,
  output logic         enable,
  output logic         dec,
  output logic         load,
  output logic [N-1:0] load_value
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int SW   = N + 3;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  logic [SW-1:0] sync1_q, sync2_q;
  logic [2:0]    db;

  // Bit order: {load_sw, load, down, up}
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {load_sw, btn_load, btn_down, btn_up};
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [DW-1:0] cnt_q;
    logic          state_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        state_q <= 1'b0;
      end else if (sync2_q[g] == state_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        state_q <= sync2_q[g];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign db[g] = state_q;
  end

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    pair_q;
  logic          ld_prev_q;
  logic [1:0]    pair;
  logic          active;
  logic          load_rise;
  logic          step_c;

  assign pair      = {db[1], db[0]};
  assign active    = db[0] ^ db[1];
  assign load_rise = db[2] & ~ld_prev_q;

  // A held pair that changes in any way aborts the hold without stepping.
  always_comb begin
    step_c = 1'b0;
    case (state_q)
      S_IDLE:   step_c = active;
      S_HOLD:   step_c = (pair == pair_q) && (timer_q == TW'(REPEAT_DELAY - 1));
      S_REPEAT: step_c = (pair == pair_q) && (timer_q == TW'(REPEAT_RATE - 1));
      default:  step_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pair_q     <= '0;
      ld_prev_q  <= 1'b0;
      enable     <= 1'b0;
      dec        <= 1'b0;
      load       <= 1'b0;
      load_value <= '0;
    end else begin
      ld_prev_q <= db[2];
      load      <= load_rise;
      if (load_rise) load_value <= sync2_q[SW-1:3];
      // Load takes priority; a colliding step is dropped, FSM still advances.
      enable <= step_c & ~load_rise;
      dec    <= step_c & ~load_rise & db[1];

      case (state_q)
        S_IDLE: begin
          if (active) begin
            state_q <= S_HOLD;
            timer_q <= '0;
            pair_q  <= pair;
          end
        end
        S_HOLD: begin
          if (pair != pair_q) begin
            state_q <= S_IDLE;
          end else if (step_c) begin
            state_q <= S_REPEAT;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (pair != pair_q) state_q <= S_IDLE;
          else if (step_c)    timer_q <= '0;
          else                timer_q <= timer_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_cmd_gen.md
# counter_cmd_gen

- Front-end command generator for the team's N-bit up/down counter with load.
- Turns three raw push-buttons (up, down, load) and an N-bit switch bank into clean single-cycle `enable`/`dec`/`load` strobes plus a `load_value` bus that connect directly to the counter's control inputs.
- Provides synchronization, debouncing and a hold-to-auto-repeat state machine, so the counter steps once per press, or steadily while a button is held.

## Interface
- N, 4, width of `load_sw` and `load_value`
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button change (≥1)
- REPEAT_DELAY, 16, cycles from first step to first auto-repeat step (≥1)
- REPEAT_RATE, 4, cycles between auto-repeat steps (≥1)

- clock  in  1  single system clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous assertion, active-low
- btn_up  in  1  raw async button, count up
- btn_down  in  1  raw async button, count down
- btn_load  in  1  raw async button, load switches into counter
- load_sw  in  N  raw async switch bank
- enable  out  1  one-cycle step strobe to counter
- dec  out  1  step direction, valid only when `enable`=1 (1 = down); 0 otherwise
- load  out  1  one-cycle load strobe to counter
- load_value  out  N  value to load, stable from the `load` cycle until the next load

## Operation
- Synchronization: each button and each `load_sw` bit passes through a 2-flop synchronizer.
- Debounce, one per button:
  - Keeps a debounced state and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while the synced input differs from the debounced state and clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES have no effect.
- Step FSM, driven by debounced up/down. "Active" means exactly one of them is high.
  - States: IDLE, HOLD, REPEAT. Repeat timer width is clog2(max(REPEAT_DELAY, REPEAT_RATE)).
  - IDLE: on becoming active → emit step, timer=0, go HOLD.
  - HOLD: timer increments; at REPEAT_DELAY-1 → emit step, timer=0, go REPEAT.
  - REPEAT: timer increments; at REPEAT_RATE-1 → emit step, timer=0.
  - HOLD/REPEAT: any change in the debounced {up, down} pair (release, second button pressed, or direction swap) → IDLE, no step that cycle. A new press needs a fresh IDLE→HOLD transition.
  - Both up and down debounced high: FSM stays IDLE; no steps are emitted.
- Emitting a step: registered `enable`=1 for exactly one cycle, with `dec`=1 if down else 0.
- Load:
  - A rising edge of debounced load produces registered `load`=1 for one cycle.
  - In the same cycle, `load_value` captures the synced `load_sw`. It holds that value afterwards.
  - No repeat while load is held.
- Simultaneous load and step in the same cycle:
  - `load` wins; `enable` is forced to 0 for that cycle.
  - The suppressed step is dropped, not deferred.
  - FSM state and timer advance normally.
- `enable` and `load` are never high in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `enable`=0, `dec`=0, `load`=0, `load_value`=0. Debounced states=0, FSM=IDLE, all counters=0.
- Reset takes effect immediately on `reset_n` low, without waiting for a clock.
- Press latency: a raw button change held stable lands in the synced value at edge 2 and is debounced at edge 2+DEBOUNCE_CYCLES. The strobe is high in the cycle after edge 3+DEBOUNCE_CYCLES (edge 7 at defaults).
- Repeat cadence: the second step comes REPEAT_DELAY cycles after the first; later steps follow every REPEAT_RATE cycles.
- Release latency: same DEBOUNCE_CYCLES+3 edges. Steps may still occur until the debounced release reaches the FSM; none occur afterwards.
- Reset mid-hold: after `reset_n` is released with a button still held, the button is re-debounced from 0, and the first step occurs DEBOUNCE_CYCLES+3 edges after release of reset.

## Test plan
- Reset with all buttons released, `load_sw`=4'h5 → all outputs 0 during reset and for 20 cycles after.
- `btn_up` high 10 cycles, then low (defaults) → exactly one `enable` pulse, at edge 7 after the press, with `dec`=0; no further pulses for 50 cycles.
- `btn_down` held 60 cycles → `enable` pulses at edges 7, 23, 27, 31, …, spaced 4 apart, all with `dec`=1; none later than 7 edges after release.
- `btn_up` glitch high for 3 cycles, then low → no `enable`, debounced state unchanged.
- `load_sw`=4'hA, `btn_load` press → `load`=1 for exactly one cycle at edge 7, `load_value`=4'hA; `load_value` stays 4'hA after `load_sw` changes to 4'h3 without a new press.
- `btn_up` and `btn_down` both held 40 cycles → no `enable`. Then, separately, `btn_up` held into REPEAT, `reset_n` pulsed low mid-cycle → outputs 0 immediately; first new pulse 7 edges after reset release.
